// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: op modes, error codes, FSM states.
package alu_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] err_t;

    localparam mode_t MODE_MULU = 2'd0;
    localparam mode_t MODE_DIVU = 2'd1;
    localparam mode_t MODE_AND  = 2'd2;
    localparam mode_t MODE_OR   = 2'd3;

    localparam err_t ERR_OK      = 2'd0;
    localparam err_t ERR_DIV0    = 2'd1;
    localparam err_t ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
    localparam int          ALU_MAX_LAT = 34;

    // Logic ops only define the low word; the ALU may leave junk above it.
    function automatic logic [63:0] fmt_result(input mode_t m, input logic [63:0] r);
        fmt_result = ((m == MODE_MULU) || (m == MODE_DIVU)) ? r : {32'b0, r[31:0]};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-issue and response channels; master = controller side, slave = requester/ALU side.
interface alu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    import alu_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    mode_t            cmd_mode;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic             alu_valid;
    mode_t            alu_mode;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic             alu_ready;
    logic [63:0]      alu_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    err_t             rsp_err;

    modport master (
        input  cmd_valid, cmd_mode, cmd_a, cmd_b, cmd_tag, alu_ready, alu_out, rsp_ready,
        output cmd_ready, alu_valid, alu_mode, alu_a, alu_b, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_a, cmd_b, cmd_tag, alu_ready, alu_out, rsp_ready,
        input  cmd_ready, alu_valid, alu_mode, alu_a, alu_b, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

endinterface

// File: rtl/alu_perf_cnt.sv
// Bank of N saturating event counters, one increment per cycle each; no backpressure.
module alu_perf_cnt #(
    parameter int N     = 3,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              inc,
    output logic [N-1:0][CNT_W-1:0]   cnt
);

    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N; i++) begin
            if (inc[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to the multi-cycle ALU; div-by-zero answered at T+1, watchdog aborts WAIT after TIMEOUT cycles.
// One outstanding op: cmd_ready low until the response handshakes. ALU_ISSUE_PERF_EN adds perf counters.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
`ifdef ALU_ISSUE_PERF_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.master  bus,
    output logic              busy
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_ops,
    output logic [CNT_W-1:0]  perf_wait_cyc,
    output logic [CNT_W-1:0]  perf_timeouts
`endif
);

    localparam int              TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             alu_valid_q, alu_valid_d;
    mode_t            mode_q, mode_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [63:0]      data_q, data_d;
    err_t             err_q, err_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             rsp_hs;

    assign rsp_hs = rsp_valid_q && bus.rsp_ready;

    always_comb begin
        state_d     = state_q;
        alu_valid_d = 1'b0;
        mode_d      = mode_q;
        a_d         = a_q;
        b_d         = b_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        data_d      = data_q;
        err_d       = err_q;
        timer_d     = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    mode_d = bus.cmd_mode;
                    a_d    = bus.cmd_a;
                    b_d    = bus.cmd_b;
                    tag_d  = bus.cmd_tag;
                    if ((bus.cmd_mode == MODE_DIVU) && (bus.cmd_b == 32'd0)) begin
                        data_d      = {bus.cmd_a, DIV0_QUOT};
                        err_d       = ERR_DIV0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        alu_valid_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A completion in the final watchdog cycle still counts as success.
                if (bus.alu_ready) begin
                    data_d      = fmt_result(mode_q, bus.alu_out);
                    err_d       = ERR_OK;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (timer_q == TMR_LAST) begin
                    data_d      = 64'd0;
                    err_d       = ERR_TIMEOUT;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_valid_q <= 1'b0;
            mode_q      <= MODE_MULU;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            data_q      <= '0;
            err_q       <= ERR_OK;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            alu_valid_q <= alu_valid_d;
            mode_q      <= mode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            data_q      <= data_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign bus.alu_valid = alu_valid_q;
    assign bus.alu_mode  = mode_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_tag   = tag_q;
    assign bus.rsp_err   = err_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [2:0]            perf_inc;
    logic [2:0][CNT_W-1:0] perf_cnt;

    assign perf_inc = {rsp_hs && (err_q == ERR_TIMEOUT), state_q == ST_WAIT, rsp_hs};

    alu_perf_cnt #(.N(3), .CNT_W(CNT_W)) u_perf (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (perf_inc),
        .cnt   (perf_cnt)
    );

    assign perf_ops      = perf_cnt[0];
    assign perf_wait_cyc = perf_cnt[1];
    assign perf_timeouts = perf_cnt[2];
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural multi-cycle ALU stand-in.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.TAG_W(4)) bus ();

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops, perf_wait_cyc, perf_timeouts;
`endif

    alu_issue_ctrl #(.TAG_W(4), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_ops      (perf_ops),
        .perf_wait_cyc (perf_wait_cyc),
        .perf_timeouts (perf_timeouts)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ALU stand-in: mulu/divu ready sampled 33 edges after valid, and/or 2 edges after.
    logic alu_hang = 1'b0;
    int   inject_req = 0;
    initial begin
        int          lat_cnt;
        int          inject_done;
        logic        valid_seen;
        logic [1:0]  m;
        logic [31:0] a, b;
        logic [63:0] res_pend;
        lat_cnt = 0;
        inject_done = 0;
        res_pend = '0;
        bus.alu_ready = 1'b0;
        bus.alu_out = '0;
        forever begin
            @(negedge clk);
            valid_seen = bus.alu_valid;
            m = bus.alu_mode;
            a = bus.alu_a;
            b = bus.alu_b;
            @(posedge clk);
            #1;
            bus.alu_ready = 1'b0;
            if (!rst_n) begin
                lat_cnt = 0;
            end else begin
                if (lat_cnt > 0) begin
                    lat_cnt--;
                    if (lat_cnt == 0 && !alu_hang) begin
                        bus.alu_ready = 1'b1;
                        bus.alu_out = res_pend;
                    end
                end
                if (inject_req != inject_done) begin
                    inject_done++;
                    bus.alu_ready = 1'b1;
                    bus.alu_out = 64'hBAD0_BAD0_BAD0_BAD0;
                end
                if (valid_seen) begin
                    case (m)
                        MODE_MULU: res_pend = {32'b0, a} * {32'b0, b};
                        MODE_DIVU: res_pend = {a % b, a / b};
                        MODE_AND:  res_pend = {32'hDEAD_BEEF, a & b};
                        default:   res_pend = {32'hDEAD_BEEF, a | b};
                    endcase
                    lat_cnt = (m == MODE_MULU || m == MODE_DIVU) ? ALU_MAX_LAT - 2 : 1;
                end
            end
        end
    end

    // Runs one command; k counts negedges after the handshake edge T (k=1 is "T+1").
    task automatic do_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tg, input int hold,
                         output int alu_k, output int alu_n, output int rsp_k,
                         output logic [63:0] d, output logic [3:0] t, output logic [1:0] e,
                         output logic stable);
        int w;
        w = 0;
        alu_k = -1; alu_n = 0; rsp_k = -1;
        d = '0; t = '0; e = '0; stable = 1'b1;
        while (!bus.cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_mode = m;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_tag = tg;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.alu_valid) begin
                alu_n++;
                if (alu_k < 0) alu_k = k;
            end
            if (bus.rsp_valid) begin
                rsp_k = k;
                break;
            end
            if (bus.cmd_ready) stable = 1'b0;
        end
        if (rsp_k < 0) begin
            chk("rsp_never_valid", 64'd0, 64'd1);
            return;
        end
        d = bus.rsp_data;
        t = bus.rsp_tag;
        e = bus.rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== d || bus.rsp_tag !== t ||
                bus.rsp_err !== e || bus.cmd_ready) stable = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        chk("post_hs_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    endtask

    initial begin
        int          ak, an, rk;
        logic [63:0] d;
        logic [3:0]  t;
        logic [1:0]  e;
        logic        st;
        logic        quiet;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_tag = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_alu_valid", {63'd0, bus.alu_valid}, 64'd0);
        chk("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
        chk("rst_alu_mode", {62'd0, bus.alu_mode}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_data", bus.rsp_data, 64'd0);
        chk("rst_rsp_tag_err", {58'd0, bus.rsp_tag, bus.rsp_err}, 64'd0);
        chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(MODE_MULU, 32'd7, 32'd6, 4'd3, 0, ak, an, rk, d, t, e, st);
        chk("mulu_alu_k", 64'(ak), 64'd1);
        chk("mulu_alu_n", 64'(an), 64'd1);
        chk("mulu_rsp_k", 64'(rk), 64'd35);
        chk("mulu_data", d, 64'd42);
        chk("mulu_tag", {60'd0, t}, 64'd3);
        chk("mulu_err", {62'd0, e}, 64'd0);
        chk("mulu_busy_cmd_ready", {63'd0, st}, 64'd1);

        do_op(MODE_DIVU, 32'd100, 32'd7, 4'd5, 0, ak, an, rk, d, t, e, st);
        chk("divu_rsp_k", 64'(rk), 64'd35);
        chk("divu_data", d, {32'd2, 32'd14});
        chk("divu_tag_err", {58'd0, t, e}, {58'd0, 4'd5, 2'd0});

        do_op(MODE_DIVU, 32'h1234, 32'd0, 4'd6, 0, ak, an, rk, d, t, e, st);
        chk("div0_alu_n", 64'(an), 64'd0);
        chk("div0_rsp_k", 64'(rk), 64'd1);
        chk("div0_data", d, 64'h0000_1234_FFFF_FFFF);
        chk("div0_err", {62'd0, e}, 64'd1);

        do_op(MODE_AND, 32'hF0F0_00FF, 32'h0FF0_FF0F, 4'd7, 10, ak, an, rk, d, t, e, st);
        chk("and_rsp_k", 64'(rk), 64'd4);
        chk("and_data", d, 64'h0000_0000_00F0_000F);
        chk("and_stable", {63'd0, st}, 64'd1);
        chk("and_err", {62'd0, e}, 64'd0);

        do_op(MODE_OR, 32'h1200_0034, 32'h0000_5600, 4'd8, 0, ak, an, rk, d, t, e, st);
        chk("or_rsp_k", 64'(rk), 64'd4);
        chk("or_data", d, 64'h0000_0000_1200_5634);

        alu_hang = 1'b1;
        do_op(MODE_MULU, 32'd3, 32'd3, 4'd9, 0, ak, an, rk, d, t, e, st);
        chk("tmo_rsp_k", 64'(rk), 64'd66);
        chk("tmo_err", {62'd0, e}, 64'd2);
        chk("tmo_data", d, 64'd0);
        chk("tmo_tag", {60'd0, t}, 64'd9);
        inject_req++;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid || busy) quiet = 1'b0;
        end
        chk("tmo_late_ready_dropped", {63'd0, quiet}, 64'd1);
        alu_hang = 1'b0;

        bus.cmd_valid = 1'b1;
        bus.cmd_mode = MODE_MULU;
        bus.cmd_a = 32'd5;
        bus.cmd_b = 32'd5;
        bus.cmd_tag = 4'd2;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("arst_alu_valid", {63'd0, bus.alu_valid}, 64'd0);
        chk("arst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(MODE_MULU, 32'hFFFF_FFFF, 32'd2, 4'd4, 0, ak, an, rk, d, t, e, st);
        chk("post_rst_rsp_k", 64'(rk), 64'd35);
        chk("post_rst_data", d, 64'h0000_0001_FFFF_FFFE);
        chk("post_rst_tag_err", {58'd0, t, e}, {58'd0, 4'd4, 2'd0});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
